fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction queue between the fetch stage and decode.
- Each cycle it captures the fetched {PC, instruction} pair and buffers up to DEPTH entries.
- It presents them in order to decode under a valid/ready handshake and back-pressures fetch with a stall when full.
- On a taken branch or an exception it flushes all buffered entries so decode never sees wrong-path instructions.

Parameters:
DEPTH, 4, number of queue entries; power of two, minimum 2
AW, 64, width of the PC field
IW, 32, width of the instruction field

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset; clears the queue immediately when low
push_valid_F  input  1  fetch presents a valid {pc_F, instr_F} this cycle
pc_F  input  AW  address of the fetched instruction (fetch's imem address)
instr_F  input  IW  instruction word returned by instruction memory
stall_F  output  1  high = queue cannot accept; fetch must hold its PC
flush  input  1  taken-branch or exception redirect; discard all entries
pop_ready_D  input  1  decode accepts the head entry this cycle
pop_valid_D  output  1  head entry valid
pc_D  output  AW  PC of the head entry
instr_D  output  IW  instruction of the head entry
count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH

Behaviour:
- Reset (reset low, asynchronous):
  - read pointer, write pointer and count go to 0.
  - pop_valid_D=0, stall_F=0.
  - pc_D and instr_D read 0.
  - Storage array contents need not be cleared.
- Push:
  - Occurs when push_valid_F && !stall_F && !flush.
  - Writes {pc_F, instr_F} at the write pointer.
  - Write pointer increments mod DEPTH (natural wrap).
- Pop:
  - Occurs when pop_valid_D && pop_ready_D && !flush.
  - Read pointer increments mod DEPTH.
- Count update, when flush is low:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged.
- stall_F = (count == DEPTH). Purely combinational from registered count; does not depend on pop_ready_D (no same-cycle pass-through when full).
- pop_valid_D = (count != 0).
- pc_D and instr_D:
  - When pop_valid_D=1: the entry at the read pointer.
  - When count==0: forced to 0.
- Latency: an entry pushed in cycle N is first visible at pc_D/instr_D in cycle N+1. There is no combinational input-to-output bypass.
- Head stability: while pop_valid_D=1 and pop_ready_D=0, pc_D and instr_D stay constant.
- Flush:
  - Synchronous; takes priority over push and pop in the same cycle.
  - Next cycle: count=0, pointers=0, pop_valid_D=0, stall_F=0.
  - A push presented in the flush cycle is dropped. The redirected PC is fetched the following cycle.
- Boundary cases:
  - Full (count==DEPTH) with pop: count becomes DEPTH-1 and stall_F drops the next cycle.
  - Full with push_valid_F: ignored. Fetch must hold, because stall_F is fed to its PC register enable.
  - Empty with pop_ready_D: no effect; count never underflows.
  - Push into an empty queue with pop_ready_D high: only the push takes effect, because pop_valid_D is 0 that cycle.
- Reset asserted mid-operation: all entries are lost immediately and outputs take their reset values asynchronously. The first push after reset release lands in entry 0.
- No X propagation: outputs are defined whenever reset is low or count==0.

Test Plan:
- Reset then idle: reset low 2 cycles, release -> count=0, pop_valid_D=0, stall_F=0, pc_D=0, instr_D=0.
- Single entry latency: push pc_F=0x100, instr_F=0x8B020020 in cycle 1 with pop_ready_D=0 -> cycle 2: pop_valid_D=1, pc_D=0x100, instr_D=0x8B020020, count=1. Pop in cycle 2 -> cycle 3: count=0, pop_valid_D=0.
- Fill and stall:
  - Stimulus: push PCs 0x0,0x4,0x8,0xC with pop_ready_D=0.
  - After the 4th push: count=4, stall_F=1.
  - A 5th push of 0x10 is ignored; count stays 4 and the head stays 0x0.
- Drain with wrap:
  - Stimulus: from full, pop every cycle while pushing 0x10,0x14 as stall_F permits.
  - Required output order: 0x0,0x4,0x8,0xC,0x10,0x14; the write pointer wraps past entry 3 correctly.
- Flush priority:
  - Stimulus: count=3 (0x20,0x24,0x28); in one cycle assert flush with push_valid_F=1 (pc_F=0x2C) and pop_ready_D=1.
  - Next cycle: count=0, pop_valid_D=0, and 0x2C never appears.
  - A subsequent push of 0x400 appears at pc_D one cycle later.
- Async reset mid-stream: with count=2, pull reset low between clock edges -> pop_valid_D=0 and count=0 immediately, before the next edge.

Source files
------------

// File: rtl/fetch_queue.sv
// In-order instruction queue between fetch and decode: buffers {pc, instr} pairs,
// stalls fetch when full and discards all entries on a redirect flush.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 64,
  parameter int IW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_valid_F,
  input  logic [AW-1:0]            pc_F,
  input  logic [IW-1:0]            instr_F,
  output logic                     stall_F,
  input  logic                     flush,
  input  logic                     pop_ready_D,
  output logic                     pop_valid_D,
  output logic [AW-1:0]            pc_D,
  output logic [IW-1:0]            instr_D,
  output logic [$clog2(DEPTH)+1-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] pc_mem    [DEPTH];
  logic [IW-1:0] instr_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt_q;
  logic          push;
  logic          pop;

  // Flush wins over both handshakes in the same cycle.
  assign push = push_valid_F && !stall_F && !flush;
  assign pop  = pop_valid_D && pop_ready_D && !flush;

  assign count       = cnt_q;
  assign stall_F     = (cnt_q == CW'(DEPTH));
  assign pop_valid_D = (cnt_q != '0);
  assign pc_D        = pop_valid_D ? pc_mem[rd_ptr]    : '0;
  assign instr_D     = pop_valid_D ? instr_mem[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      // Pointers are exactly PW bits wide, so increments wrap mod DEPTH.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only observable once
  // count covers them, and the outputs are forced to zero when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= pc_F;
      instr_mem[wr_ptr] <= instr_F;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue: latency, fill/stall, wrap,
// flush priority and asynchronous reset.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 64;
  localparam int IW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          push_valid_F;
  logic [AW-1:0] pc_F;
  logic [IW-1:0] instr_F;
  logic          stall_F;
  logic          flush;
  logic          pop_ready_D;
  logic          pop_valid_D;
  logic [AW-1:0] pc_D;
  logic [IW-1:0] instr_D;
  logic [2:0]    count;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_queue #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
    .clk          (clk),
    .reset        (reset),
    .push_valid_F (push_valid_F),
    .pc_F         (pc_F),
    .instr_F      (instr_F),
    .stall_F      (stall_F),
    .flush        (flush),
    .pop_ready_D  (pop_ready_D),
    .pop_valid_D  (pop_valid_D),
    .pc_D         (pc_D),
    .instr_D      (instr_D),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [AW-1:0] pc, input logic pr, input logic fl);
    push_valid_F = pv;
    pc_F         = pc;
    instr_F      = IW'(32'hE000_0000 | pc[31:0]);
    pop_ready_D  = pr;
    flush        = fl;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(pop_valid_D), 64'd0);
    reset = 1'b1;
    step();
    check("idle_count", 64'(count), 64'd0);
    check("idle_valid", 64'(pop_valid_D), 64'd0);
    check("idle_stall", 64'(stall_F), 64'd0);
    check("idle_pc", pc_D, 64'd0);
    check("idle_instr", 64'(instr_D), 64'd0);

    // Single entry latency
    drive(1'b1, 64'h100, 1'b0, 1'b0);
    instr_F = 32'h8B02_0020;
    check("same_cycle_no_bypass", 64'(pop_valid_D), 64'd0);
    step();
    drive(1'b0, '0, 1'b1, 1'b0);
    check("lat_valid", 64'(pop_valid_D), 64'd1);
    check("lat_pc", pc_D, 64'h100);
    check("lat_instr", 64'(instr_D), 64'h8B02_0020);
    check("lat_count", 64'(count), 64'd1);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("pop1_count", 64'(count), 64'd0);
    check("pop1_valid", 64'(pop_valid_D), 64'd0);
    check("pop1_pc_zero", pc_D, 64'd0);

    // Fill and stall (write pointer starts at entry 1 here)
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'(i * 4), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    check("full_count", 64'(count), 64'd4);
    check("full_stall", 64'(stall_F), 64'd1);
    check("full_head", pc_D, 64'h0);
    check("full_head_instr", 64'(instr_D), 64'hE000_0000);
    drive(1'b1, 64'h10, 1'b0, 1'b0);
    step();
    check("ovf_count", 64'(count), 64'd4);
    check("ovf_head", pc_D, 64'h0);
    check("ovf_stall", 64'(stall_F), 64'd1);

    // Drain with wrap: pop every cycle, push 0x10/0x14 when allowed
    drive(1'b1, 64'h10, 1'b1, 1'b0);
    step();
    check("drain0_pc", pc_D, 64'h4);
    check("drain0_count", 64'(count), 64'd3);
    check("drain0_stall", 64'(stall_F), 64'd0);
    drive(1'b1, 64'h10, 1'b1, 1'b0);
    step();
    check("drain1_pc", pc_D, 64'h8);
    check("drain1_count", 64'(count), 64'd3);
    drive(1'b1, 64'h14, 1'b1, 1'b0);
    step();
    check("drain2_pc", pc_D, 64'hC);
    check("drain2_count", 64'(count), 64'd3);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    check("drain3_pc", pc_D, 64'h10);
    check("drain3_instr", 64'(instr_D), 64'hE000_0010);
    check("drain3_count", 64'(count), 64'd2);
    step();
    check("drain4_pc", pc_D, 64'h14);
    check("drain4_count", 64'(count), 64'd1);
    step();
    check("drain5_count", 64'(count), 64'd0);
    check("drain5_valid", 64'(pop_valid_D), 64'd0);
    step();
    check("underflow_count", 64'(count), 64'd0);

    // Push into empty with pop_ready high: only the push happens
    drive(1'b1, 64'h20, 1'b1, 1'b0);
    step();
    check("pushempty_count", 64'(count), 64'd1);
    check("pushempty_pc", pc_D, 64'h20);
    drive(1'b1, 64'h24, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h28, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("preflush_count", 64'(count), 64'd3);
    check("hold_pc", pc_D, 64'h20);

    // Flush priority over push and pop
    drive(1'b1, 64'h2C, 1'b1, 1'b1);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(pop_valid_D), 64'd0);
    check("flush_stall", 64'(stall_F), 64'd0);
    check("flush_pc", pc_D, 64'd0);
    step();
    check("flush_drop_count", 64'(count), 64'd0);
    drive(1'b1, 64'h400, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h404, 1'b0, 1'b0);
    check("redirect_pc", pc_D, 64'h400);
    check("redirect_count", 64'(count), 64'd1);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("prereset_count", 64'(count), 64'd2);

    // Asynchronous reset between edges
    #2;
    reset = 1'b0;
    #1;
    check("areset_valid", 64'(pop_valid_D), 64'd0);
    check("areset_count", 64'(count), 64'd0);
    check("areset_pc", pc_D, 64'd0);
    check("areset_stall", 64'(stall_F), 64'd0);
    #1;
    reset = 1'b1;
    drive(1'b1, 64'h500, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("postreset_pc", pc_D, 64'h500);
    check("postreset_count", 64'(count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
